// File: rtl/datapath_pkg.sv
// Shared datapath types: functional-unit count, writeback holding-buffer layout
// and the tag type used by dispatch, the status table and the writeback arbiter.
package datapath_pkg;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = $clog2(NUM_FU);
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef logic [TAG_W-1:0] fu_tag_t;

    typedef struct packed {
        logic              full;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_buf_t;

endpackage

// File: rtl/writeback_arb_rr_arbiter.sv
// Combinational round-robin arbiter: scans i_req upward from i_ptr with wrap and
// returns the first requester as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    // Priority scan starting at the pointer; the first hit wins.
    always_comb begin : scan
        int   c;
        logic found;
        o_grant = {N{1'b0}};
        o_idx   = {IW{1'b0}};
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(i_ptr) + k;
            if (c >= N) begin
                c = c - N;
            end else begin
                c = c;
            end
            if (!found && i_req[c]) begin
                found      = 1'b1;
                o_grant[c] = 1'b1;
                o_idx      = IW'(c);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/writeback_arb.sv
// Writeback arbiter: one holding buffer per FU, round-robin retirement of one
// result per cycle, and a busy-clear that only fires if this FU still owns rd.
module writeback_arb #(
    parameter int NUM_FU = datapath_pkg::NUM_FU,
    parameter int TAG_W  = $clog2(NUM_FU),
    parameter int REG_W  = datapath_pkg::REG_W,
    parameter int DATA_W = datapath_pkg::DATA_W
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*REG_W-1:0]  fu_rd,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic                     wb_write,
    output logic [REG_W-1:0]         wb_sel,
    output logic [DATA_W-1:0]        wb_data,
    output logic [TAG_W-1:0]         wb_tag,
    input  logic                     rst_busy,
    input  logic [TAG_W-1:0]         rst_tag,
    output logic                     rst_clear
);

    datapath_pkg::wb_buf_t r_buf [NUM_FU];
    logic [TAG_W-1:0]      r_rr_ptr;
    logic [NUM_FU-1:0]     w_full;
    logic [NUM_FU-1:0]     w_grant;
    logic [TAG_W-1:0]      w_idx;
    logic                  w_any;

    // Collect the occupancy vector for the arbiter.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_full[i] = r_buf[i].full;
        end
    end

    rr_arbiter #(.N(NUM_FU), .IW(TAG_W)) u_rr (
        .i_req   (w_full),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_any = |w_grant;

    // A buffer being drained this cycle can take a new result at the same edge.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = ~r_buf[i].full | w_grant[i];
        end
    end

    // Output mux; everything reads zero when nothing is granted.
    always_comb begin
        if (w_any) begin
            wb_write = 1'b1;
            wb_sel   = r_buf[w_idx].rd;
            wb_data  = r_buf[w_idx].data;
            wb_tag   = w_idx;
        end else begin
            wb_write = 1'b0;
            wb_sel   = {REG_W{1'b0}};
            wb_data  = {DATA_W{1'b0}};
            wb_tag   = {TAG_W{1'b0}};
        end
    end

    // A younger dispatch to the same register re-tags the entry; leave it busy then.
    assign rst_clear = wb_write & rst_busy & (rst_tag == wb_tag);

    // Holding buffers: flush beats handshake, handshake beats drain.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_buf[i] <= '{full: 1'b0, rd: {REG_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_buf[i].full <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    r_buf[i].full <= 1'b1;
                    r_buf[i].rd   <= fu_rd[i*REG_W +: REG_W];
                    r_buf[i].data <= fu_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_buf[i].full <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves just past the winner; flush leaves it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr <= {TAG_W{1'b0}};
        end else if (flush) begin
            r_rr_ptr <= r_rr_ptr;
        end else if (w_any) begin
            if (int'(w_idx) == NUM_FU - 1) begin
                r_rr_ptr <= {TAG_W{1'b0}};
            end else begin
                r_rr_ptr <= w_idx + {{(TAG_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_writeback_arb.sv
// Directed bench for writeback_arb: reset, single retire, round-robin order,
// WAW clear guard, back-to-back streaming, flush and asynchronous reset.
module tb_writeback_arb;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  fu_valid = 4'b0000;
    logic [3:0]  fu_ready;
    logic [19:0] fu_rd = 20'h0;
    logic [127:0] fu_data = 128'h0;
    logic        wb_write;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic [1:0]  wb_tag;
    logic        rst_busy = 1'b0;
    logic [1:0]  rst_tag = 2'd0;
    logic        rst_clear;

    int checks = 0;
    int errors = 0;

    writeback_arb dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_data(fu_data),
        .wb_write(wb_write), .wb_sel(wb_sel), .wb_data(wb_data), .wb_tag(wb_tag),
        .rst_busy(rst_busy), .rst_tag(rst_tag), .rst_clear(rst_clear)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1'b0; fu_valid = 4'b0000; flush = 1'b0; rst_busy = 1'b0; rst_tag = 2'd0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] data);
        fu_rd[i*5 +: 5]    = rd;
        fu_data[i*32 +: 32] = data;
    endtask

    // Present the given FUs for one posedge, then drop valid; ends at edge+1.
    task automatic present(input logic [3:0] mask);
        fu_valid = mask;
        @(posedge CLK); #1;
        fu_valid = 4'b0000;
    endtask

    task automatic test_reset();
        @(posedge CLK); #1;
        nRST = 1'b0; fu_valid = 4'b1111; rst_busy = 1'b1; rst_tag = 2'd0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL reset_wb_write got %b exp 0", wb_write); end
        checks++; if ({wb_sel, wb_data, wb_tag, rst_clear} !== 40'h0) begin errors++; $display("FAIL reset_outputs got sel=%h data=%h tag=%h clr=%b exp 0", wb_sel, wb_data, wb_tag, rst_clear); end
        checks++; if (fu_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b exp 1111", fu_ready); end
        fu_valid = 4'b0000; rst_busy = 1'b0;
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL idle_after_reset cycle %0d got %b exp 0", k, wb_write); end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_fu(2, 5'd7, 32'hDEADBEEF);
        rst_busy = 1'b1; rst_tag = 2'd2;
        present(4'b0100);
        checks++; if (wb_write !== 1'b1) begin errors++; $display("FAIL single_write got %b exp 1", wb_write); end
        checks++; if (wb_sel !== 5'd7) begin errors++; $display("FAIL single_sel got %0d exp 7", wb_sel); end
        checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", wb_data); end
        checks++; if (wb_tag !== 2'd2) begin errors++; $display("FAIL single_tag got %0d exp 2", wb_tag); end
        checks++; if (rst_clear !== 1'b1) begin errors++; $display("FAIL single_clear got %b exp 1", rst_clear); end
        @(posedge CLK); #1;
        checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", wb_write); end
        rst_busy = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_tag;
        do_reset();
        for (int i = 0; i < 4; i++) set_fu(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
        present(4'b1111);
        for (int k = 0; k < 4; k++) begin
            exp_tag = 2'(k);
            checks++; if (wb_write !== 1'b1 || wb_tag !== exp_tag || wb_data !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL rr0_order slot %0d got w=%b tag=%0d data=%h exp tag=%0d", k, wb_write, wb_tag, wb_data, exp_tag); end
            @(posedge CLK); #1;
        end
        checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL rr0_drained got %b exp 0", wb_write); end
        // One retire from FU0 moves the pointer to 1.
        present(4'b0001);
        @(posedge CLK); #1;
        present(4'b1111);
        for (int k = 0; k < 4; k++) begin
            exp_tag = 2'((k + 1) % 4);
            checks++; if (wb_write !== 1'b1 || wb_tag !== exp_tag || wb_sel !== 5'(10 + int'(exp_tag))) begin errors++; $display("FAIL rr1_order slot %0d got w=%b tag=%0d sel=%0d exp tag=%0d", k, wb_write, wb_tag, wb_sel, exp_tag); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_waw_guard();
        do_reset();
        set_fu(1, 5'd3, 32'h0000_1234);
        rst_busy = 1'b1; rst_tag = 2'd0;
        present(4'b0010);
        checks++; if (wb_write !== 1'b1 || wb_sel !== 5'd3 || wb_tag !== 2'd1) begin errors++; $display("FAIL waw_write got w=%b sel=%0d tag=%0d exp 1/3/1", wb_write, wb_sel, wb_tag); end
        checks++; if (rst_clear !== 1'b0) begin errors++; $display("FAIL waw_tag_mismatch got %b exp 0", rst_clear); end
        rst_busy = 1'b0; rst_tag = 2'd1; #1;
        checks++; if (rst_clear !== 1'b0) begin errors++; $display("FAIL waw_not_busy got %b exp 0", rst_clear); end
        rst_busy = 1'b1; #1;
        checks++; if (rst_clear !== 1'b1) begin errors++; $display("FAIL waw_owner_match got %b exp 1", rst_clear); end
        rst_busy = 1'b0; rst_tag = 2'd0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_fu(0, 5'd9, 32'd1);
        checks++; if (fu_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_initial got %b exp 1", fu_ready[0]); end
        fu_valid = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK); #1;
            checks++; if (fu_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready cycle %0d got %b exp 1", k, fu_ready[0]); end
            checks++; if (wb_write !== 1'b1 || wb_data !== 32'(k)) begin errors++; $display("FAIL b2b_data cycle %0d got w=%b data=%0d exp %0d", k, wb_write, wb_data, k); end
            if (k < 8) set_fu(0, 5'd9, 32'(k + 1));
            else fu_valid = 4'b0000;
        end
        @(posedge CLK); #1;
        checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", wb_write); end
    endtask

    task automatic test_flush();
        do_reset();
        set_fu(0, 5'd4, 32'h0000_0F00);
        set_fu(3, 5'd5, 32'h0000_0F03);
        set_fu(1, 5'd6, 32'h0000_0F01);
        present(4'b1001);
        checks++; if (wb_write !== 1'b1 || wb_tag !== 2'd0) begin errors++; $display("FAIL flush_pre got w=%b tag=%0d exp 1/0", wb_write, wb_tag); end
        flush = 1'b1; fu_valid = 4'b0010;
        @(posedge CLK); #1;
        flush = 1'b0; fu_valid = 4'b0000;
        checks++; if (wb_write !== 1'b0) begin errors++; $display("FAIL flush_write got %b exp 0", wb_write); end
        checks++; if (fu_ready !== 4'b1111) begin errors++; $display("FAIL flush_empty got %b exp 1111", fu_ready); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_fu(1, 5'd1, 32'h0000_0111);
        set_fu(2, 5'd2, 32'h0000_0222);
        present(4'b0110);
        @(posedge CLK); #1;
        // FU1 retired so the pointer now sits at 2 with FU2 still full.
        checks++; if (wb_write !== 1'b1 || wb_tag !== 2'd2) begin errors++; $display("FAIL arst_pre got w=%b tag=%0d exp 1/2", wb_write, wb_tag); end
        #2 nRST = 1'b0; #1;
        checks++; if (wb_write !== 1'b0 || fu_ready !== 4'b1111) begin errors++; $display("FAIL arst_immediate got w=%b ready=%b exp 0/1111", wb_write, fu_ready); end
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
        set_fu(0, 5'd8, 32'h0000_0AAA);
        set_fu(2, 5'd2, 32'h0000_0CCC);
        present(4'b0101);
        checks++; if (wb_write !== 1'b1 || wb_tag !== 2'd0 || wb_data !== 32'h0000_0AAA) begin errors++; $display("FAIL arst_ptr_zero got w=%b tag=%0d data=%h exp 1/0/aaa", wb_write, wb_tag, wb_data); end
        @(posedge CLK); #1;
        checks++; if (wb_write !== 1'b1 || wb_tag !== 2'd2) begin errors++; $display("FAIL arst_second got w=%b tag=%0d exp 1/2", wb_write, wb_tag); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_waw_guard();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
